// File: rtl/vc_writeback_buffer.sv
// vc_writeback_buffer
//   Small FIFO of dirty lines evicted from the victim cache, drained to pmem
//   one line per write transaction. Repeat evictions of a queued line are
//   merged in place, except into the head while its pmem write is in flight.
//   A combinational lookup port lets the miss path read pending lines.
//
// Ports
//   clk, reset                      clock / async active-high reset
//   in_valid, in_address, in_data   eviction input
//   in_ready                        buffer has a free entry (count < DEPTH)
//   lookup_address                  probe address from the miss path
//   lookup_hit, lookup_data         probe result (youngest matching entry)
//   drain_en                        permission to start a pmem write
//   pmem_write                      write request, held until pmem_resp
//   pmem_address, pmem_wdata        head line address/data
//   pmem_resp                       write-complete pulse
//   empty, count                    occupancy
//
// state  | meaning
// IDLE   | no pmem write outstanding; may start one when lines are queued
// WRITE  | head line presented to pmem, waiting for pmem_resp
module vc_writeback_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 12,
  parameter int DW    = 128
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [AW-1:0]                in_address,
  input  logic [DW-1:0]                in_data,
  output logic                         in_ready,
  input  logic [AW-1:0]                lookup_address,
  output logic                         lookup_hit,
  output logic [DW-1:0]                lookup_data,
  input  logic                         drain_en,
  output logic                         pmem_write,
  output logic [15:0]                  pmem_address,
  output logic [DW-1:0]                pmem_wdata,
  input  logic                         pmem_resp,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];

  logic             in_flight;
  logic             accept;
  logic             alloc;
  logic             pop;
  logic             merge;
  logic [PW-1:0]    merge_idx;
  logic [PW-1:0]    wr_idx;

  assign in_flight = (state_q == S_WRITE);
  assign in_ready  = (count_q < CW'(DEPTH));
  assign accept    = in_valid & in_ready;
  assign alloc     = accept & ~merge;
  assign pop       = in_flight & pmem_resp;
  assign wr_idx    = merge ? merge_idx : tail_q;

  // Merge target: any valid entry with the same line address, excluding the
  // head while it is being written (its data must stay stable for pmem).
  always_comb begin
    merge     = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == in_address) &&
          !(in_flight && (PW'(i) == head_q))) begin
        merge     = 1'b1;
        merge_idx = PW'(i);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(alloc) - CW'(pop);
    if (alloc) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PW'(1);
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if ((count_q != '0) && drain_en) state_d = S_WRITE;
      S_WRITE: if (pmem_resp)                   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Line storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q[wr_idx] <= in_address;
      data_q[wr_idx] <= in_data;
    end
  end

  // A match on a non-in-flight entry overrides the in-flight head: such an
  // entry is always the newer copy of that line.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = data_q[head_q];
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == lookup_address)) begin
        lookup_hit = 1'b1;
        if (!(in_flight && (PW'(i) == head_q))) lookup_data = data_q[i];
      end
    end
  end

  assign pmem_write   = in_flight;
  assign pmem_address = {addr_q[head_q], 4'b0000};
  assign pmem_wdata   = data_q[head_q];
  assign empty        = (count_q == '0);
  assign count        = count_q;

endmodule
